reg_write_arbiter: RTL and testbench

- Shares the single write port of the register file (flip-flop array, async active-low reset) between two requesters: ALU writeback (port A) and memory-load writeback (port B).
- Round-robin arbitration with req/ack handshake.
- Registered write strobe, address and data to the register file.
- Saturating conflict counter for performance visibility.

---
 rtl/reg_write_arbiter_if.sv | 31 +++
 rtl/reg_write_arbiter.sv | 97 +++++++++
 tb/tb_reg_write_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// Write-port bus for reg_write_arbiter: two writeback requesters plus the
// registered register-file write port and the conflict counter.
interface reg_write_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
);
    logic              hold;
    logic              req_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] data_a;
    logic              ack_a;
    logic              req_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] data_b;
    logic              ack_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0]  conflict_cnt;

    modport slave (
        input  hold, req_a, addr_a, data_a, req_b, addr_b, data_b,
        output ack_a, ack_b, wr_en, wr_addr, wr_data, conflict_cnt
    );

    modport master (
        output hold, req_a, addr_a, data_a, req_b, addr_b, data_b,
        input  ack_a, ack_b, wr_en, wr_addr, wr_data, conflict_cnt
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between ALU (A)
// and load (B) writeback. Define R0_DISCARD_EN to drop writes to register 0.
module reg_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
) (
    input logic                CLK,
    input logic                R,
    reg_write_arbiter_if.slave bus
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    port_e             last_grant_q, last_grant_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              grant_a, grant_b, granted, conflict, write_ok;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Acks are combinational so a requester sees its grant in the same cycle.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (R && !bus.hold) begin
            if (bus.req_a && (!bus.req_b || last_grant_q == PORT_B)) begin
                grant_a = 1'b1;
            end else if (bus.req_b) begin
                grant_b = 1'b1;
            end
        end
        granted  = grant_a | grant_b;
        conflict = !bus.hold && bus.req_a && bus.req_b;
        sel_addr = grant_a ? bus.addr_a : bus.addr_b;
        sel_data = grant_a ? bus.data_a : bus.data_b;
`ifdef R0_DISCARD_EN
        write_ok = granted && (sel_addr != '0);
`else
        write_ok = granted;
`endif
    end

    always_comb begin
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        if (write_ok) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
        end
        // A discarded R0 write still spends the round-robin turn.
        if (granted) begin
            last_grant_d = grant_a ? PORT_A : PORT_B;
        end
        if (conflict && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cnt_q        <= '0;
            last_grant_q <= PORT_B;
        end else begin
            // NOTE: state flops use non-blocking assignment so every flop samples
            // the pre-edge values regardless of statement order.
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.ack_a        = grant_a;
    assign bus.ack_b        = grant_b;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: vector table, reset/R0 sequences, then random
// traffic against a rule-level model. A CNT_W=2 copy shares the stimulus.
module tb_reg_write_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    reg_write_arbiter_if #(.DATA_W(16), .ADDR_W(3), .CNT_W(8)) bus ();
    reg_write_arbiter_if #(.DATA_W(16), .ADDR_W(3), .CNT_W(2)) bus_s ();

    assign bus_s.hold   = bus.hold;
    assign bus_s.req_a  = bus.req_a;
    assign bus_s.addr_a = bus.addr_a;
    assign bus_s.data_a = bus.data_a;
    assign bus_s.req_b  = bus.req_b;
    assign bus_s.addr_b = bus.addr_b;
    assign bus_s.data_b = bus.data_b;

    reg_write_arbiter #(.DATA_W(16), .ADDR_W(3), .CNT_W(8)) u_dut (
        .CLK(clk), .R(rst_n), .bus(bus)
    );
    reg_write_arbiter #(.DATA_W(16), .ADDR_W(3), .CNT_W(2)) u_dut_sat (
        .CLK(clk), .R(rst_n), .bus(bus_s)
    );

    typedef struct {
        logic        hold;
        logic        req_a;
        logic [2:0]  addr_a;
        logic [15:0] data_a;
        logic        req_b;
        logic [2:0]  addr_b;
        logic [15:0] data_b;
        logic        ack_a;
        logic        ack_b;
        logic        wr_en;
        logic [2:0]  wr_addr;
        logic [15:0] wr_data;
        int          cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic h, logic ra, logic [2:0] aa, logic [15:0] da,
                                logic rb, logic [2:0] ab, logic [15:0] db,
                                logic ka, logic kb, logic we, logic [2:0] wa,
                                logic [15:0] wd, int c);
        vec_t v;
        v.hold = h; v.req_a = ra; v.addr_a = aa; v.data_a = da;
        v.req_b = rb; v.addr_b = ab; v.data_b = db;
        v.ack_a = ka; v.ack_b = kb; v.wr_en = we; v.wr_addr = wa;
        v.wr_data = wd; v.cnt = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(int v, int max);
        return (v > max) ? max : v;
    endfunction

    task automatic drive(input vec_t v);
        bus.hold = v.hold;
        bus.req_a = v.req_a; bus.addr_a = v.addr_a; bus.data_a = v.data_a;
        bus.req_b = v.req_b; bus.addr_b = v.addr_b; bus.data_b = v.data_b;
    endtask

    // Called just after a falling edge; checks acks before the rising edge and
    // registered outputs just after it.
    task automatic apply_vec(input string tag, input vec_t v);
        drive(v);
        #4;
        check({tag, " ack_a"}, bus.ack_a, v.ack_a);
        check({tag, " ack_b"}, bus.ack_b, v.ack_b);
        @(posedge clk);
        #1;
        check({tag, " wr_en"}, bus.wr_en, v.wr_en);
        check({tag, " wr_addr"}, bus.wr_addr, v.wr_addr);
        check({tag, " wr_data"}, bus.wr_data, v.wr_data);
        check({tag, " cnt"}, bus.conflict_cnt, v.cnt);
        check({tag, " cnt_sat2"}, bus_s.conflict_cnt, sat(v.cnt, 3));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model state: who wins the next conflict, and the expected port.
    bit          m_prefer_a;
    int          m_cnt;
    logic        m_wr_en;
    logic [2:0]  m_addr;
    logic [15:0] m_data;

    task automatic model_cycle(output bit ga, output bit gb);
        bit          both;
        logic [2:0]  a;
        logic [15:0] d;
        both = !bus.hold && bus.req_a && bus.req_b;
        ga = !bus.hold && bus.req_a && (!bus.req_b || m_prefer_a);
        gb = !bus.hold && bus.req_b && !ga;
        #4;
        check("rnd ack_a", bus.ack_a, ga);
        check("rnd ack_b", bus.ack_b, gb);
        a = ga ? bus.addr_a : bus.addr_b;
        d = ga ? bus.data_a : bus.data_b;
        @(posedge clk);
        if (both) m_cnt++;
        m_wr_en = 1'b0;
        if (ga || gb) begin
            m_prefer_a = gb;
`ifdef R0_DISCARD_EN
            if (a != 3'd0) begin
                m_wr_en = 1'b1; m_addr = a; m_data = d;
            end
`else
            m_wr_en = 1'b1; m_addr = a; m_data = d;
`endif
        end
        #1;
        check("rnd wr_en", bus.wr_en, m_wr_en);
        check("rnd wr_addr", bus.wr_addr, m_addr);
        check("rnd wr_data", bus.wr_data, m_data);
        check("rnd cnt", bus.conflict_cnt, sat(m_cnt, 255));
        check("rnd cnt_sat2", bus_s.conflict_cnt, sat(m_cnt, 3));
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   busy_a, busy_b, ga, gb;
        vec_t v;

        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #7;
        check("reset wr_en", bus.wr_en, 1'b0);
        check("reset wr_addr", bus.wr_addr, 3'd0);
        check("reset wr_data", bus.wr_data, 16'h0);
        check("reset cnt", bus.conflict_cnt, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //            h ra aa  da        rb ab  db        ka kb we wa  wd        cnt
        vecs.push_back(mk(0, 1, 1, 16'h0A01, 1, 2, 16'h0B02, 1, 0, 1, 1, 16'h0A01, 1));
        vecs.push_back(mk(0, 1, 1, 16'h0A01, 1, 2, 16'h0B02, 0, 1, 1, 2, 16'h0B02, 2));
        vecs.push_back(mk(0, 1, 1, 16'h0A01, 1, 2, 16'h0B02, 1, 0, 1, 1, 16'h0A01, 3));
        vecs.push_back(mk(0, 1, 1, 16'h0A01, 1, 2, 16'h0B02, 0, 1, 1, 2, 16'h0B02, 4));
        vecs.push_back(mk(1, 1, 3, 16'h0A03, 1, 4, 16'h0B04, 0, 0, 0, 2, 16'h0B02, 4));
        vecs.push_back(mk(1, 1, 3, 16'h0A03, 1, 4, 16'h0B04, 0, 0, 0, 2, 16'h0B02, 4));
        vecs.push_back(mk(1, 1, 3, 16'h0A03, 1, 4, 16'h0B04, 0, 0, 0, 2, 16'h0B02, 4));
        vecs.push_back(mk(0, 1, 3, 16'h0A03, 1, 4, 16'h0B04, 1, 0, 1, 3, 16'h0A03, 5));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 4, 16'h0B04, 0, 1, 1, 4, 16'h0B04, 5));
        vecs.push_back(mk(0, 1, 5, 16'h1234, 0, 0, 16'h0000, 1, 0, 1, 5, 16'h1234, 5));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 5, 16'h1234, 5));
        vecs.push_back(mk(0, 1, 6, 16'h5555, 0, 0, 16'h0000, 1, 0, 1, 6, 16'h5555, 5));
        vecs.push_back(mk(0, 1, 7, 16'h7777, 1, 7, 16'h8888, 0, 1, 1, 7, 16'h8888, 6));
        vecs.push_back(mk(0, 1, 7, 16'h7777, 1, 7, 16'h8888, 1, 0, 1, 7, 16'h7777, 7));
        foreach (vecs[i]) apply_vec($sformatf("vec%0d", i), vecs[i]);

        // Asynchronous reset mid-cycle while wr_en=1 and both ports requesting.
        check("pre-reset wr_en", bus.wr_en, 1'b1);
        drive(mk(0, 1, 1, 16'h00A1, 1, 2, 16'h00B2, 0, 0, 0, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async wr_en", bus.wr_en, 1'b0);
        check("async wr_addr", bus.wr_addr, 3'd0);
        check("async wr_data", bus.wr_data, 16'h0);
        check("async cnt", bus.conflict_cnt, 8'd0);
        check("async cnt_sat2", bus_s.conflict_cnt, 2'd0);
        check("async ack_a", bus.ack_a, 1'b0);
        check("async ack_b", bus.ack_b, 1'b0);
        @(posedge clk);
        #1;
        check("in-reset wr_en", bus.wr_en, 1'b0);
        check("in-reset cnt", bus.conflict_cnt, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        apply_vec("post-rst", mk(0, 1, 1, 16'h00A1, 1, 2, 16'h00B2, 1, 0, 1, 1, 16'h00A1, 1));
`ifdef R0_DISCARD_EN
        apply_vec("r0", mk(0, 0, 0, 16'h0000, 1, 0, 16'hFFFF, 0, 1, 0, 1, 16'h00A1, 1));
`else
        apply_vec("r0", mk(0, 0, 0, 16'h0000, 1, 0, 16'hFFFF, 0, 1, 1, 0, 16'hFFFF, 1));
`endif
        apply_vec("r0-turn", mk(0, 1, 3, 16'h00A3, 1, 2, 16'h00B2, 1, 0, 1, 3, 16'h00A3, 2));

        // Random traffic; requesters hold their request until acked.
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        do_reset();
        m_prefer_a = 1'b1;
        m_cnt      = 0;
        m_wr_en    = 1'b0;
        m_addr     = 3'd0;
        m_data     = 16'h0;
        busy_a     = 1'b0;
        busy_b     = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!busy_a) begin
                bus.req_a  = ($urandom_range(0, 2) != 0);
                bus.addr_a = 3'($urandom_range(0, 7));
                bus.data_a = 16'($urandom);
            end
            if (!busy_b) begin
                bus.req_b  = ($urandom_range(0, 2) != 0);
                bus.addr_b = 3'($urandom_range(0, 7));
                bus.data_b = 16'($urandom);
            end
            bus.hold = ($urandom_range(0, 5) == 0);
            model_cycle(ga, gb);
            busy_a = bus.req_a && !ga;
            busy_b = bus.req_b && !gb;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
